shift_loop: RTL
===============

// Module: shift_loop
// PURPOSE
//  Multi-cycle AR/ARX shift engine, directly downstream of the SCD shift-count/exponent board.
//  - Takes a signed shift count from SCD's SC and operands from AR/ARX.
//  - Shifts up to STEP bit positions per clock until the count is exhausted.
//  - Returns AR/ARX plus overflow; handles LSH/LSHC/ASH/ROTC-class micro-ops.
//  Bit 0 is the MSB throughout (PDP-10 numbering).
// PARAMETERS
//  WIDTH  36  word width of AR and ARX
//  STEP   8   maximum positions shifted per clock (1..WIDTH)
//  CNTW   10  width of signed count input (matches SC[0:9])
// PORTS
//  clk      in   1      system clock; all state on rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      load operands/count, begin op (accepted only in IDLE)
//  abort    in   1      synchronous cancel; returns to IDLE, no done pulse
//  mode     in   2      00 LSH (AR only), 01 LSHC (AR,ARX 72b), 10 ASH (AR arith), 11 ROTC (72b rotate)
//  sc       in   CNTW   signed two's-complement count; >0 left, <0 right
//  ar_in    in   WIDTH  AR operand
//  arx_in   in   WIDTH  ARX operand
//  ar_out   out  WIDTH  shifted AR (registered)
//  arx_out  out  WIDTH  shifted ARX (registered; passes arx_in unchanged for LSH/ASH)
//  sc_rem   out  CNTW   remaining magnitude, zero-extended
//  busy     out  1      high in SHIFT state
//  done     out  1      one-clock pulse when results are valid
//  ov       out  1      ASH only: sticky, set if any bit shifted out of bit 1 differs from bit 0
// BEHAVIOUR
//  Reset:
//  - All outputs 0; state IDLE; async assert, sync-safe deassert is handled upstream.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: start & !abort latches operands, mode, dir = sc sign, mag = |sc|.
//    - Clears ov.
//    - If mag = 0, go to DONE; otherwise go to SHIFT.
//  - SHIFT: each clock shifts k = min(mag, STEP) positions and sets mag -= k.
//    - Goes to DONE when mag reaches 0.
//  - DONE: done = 1 for exactly one clock, then IDLE. Outputs hold until the next accepted start.
//  Count magnitude:
//  - sc = -512 gives mag = 512; the full CNTW-bit magnitude must not wrap.
//  - Non-rotate modes clip mag to 2*WIDTH (72) at load; bits past that are all gone anyway.
//    Worst case is 9 SHIFT cycles at STEP = 8.
//  - ROTC does not clip: 512 positions takes 64 SHIFT cycles.
//  Latency: start to done = ceil(mag/STEP) + 1 clocks; mag = 0 gives 1 clock.
//  Fill rules:
//  - LSH/LSHC: zero fill. LSHC: AR bit 0 is the MSB of the 72-bit pair and ARX bit 35 the LSB.
//  - ASH left: bit 0 is preserved, bits 1..35 shift, zero fill from the right; ov is evaluated per bit lost.
//  - ASH right: sign fill; bit 0 is unchanged; ov is never set.
//  - ROTC: 72-bit circular rotate.
//  Boundary cases:
//  - start while busy or in DONE: ignored. No queueing; the current op is not disturbed.
//  - abort in SHIFT: next state IDLE, busy = 0, no done. ar_out/arx_out keep the partial result (don't-care).
//  - start & abort in the same IDLE clock: abort wins, nothing is loaded.
//  - rst_n asserted mid-op: immediate IDLE with all outputs 0, no done.
//  - Reserved count range: none; every CNTW-bit value is legal.
// STRUCTURE
//  Shared package shift_pkg:
//  - WIDTH/STEP/CNTW defaults.
//  - mode encodings: SH_LSH, SH_LSHC, SH_ASH, SH_ROTC.
//  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE.
//  - localparam DWIDTH = 2*WIDTH.
//  Sub-module shift_step (combinational):
//  - Inputs: 72-bit value, k (0..STEP), dir, mode.
//  - Outputs: shifted 72-bit value and the lost-bit ov flag.
//  - Instantiated once.
//  shift_loop holds the FSM, operand/count registers and the sticky ov.
// TESTING
//  1. LSH, ar_in=36'o000000_000001, sc=+35 -> ar_out=36'o400000_000000; done 6 clocks after start; arx_out=arx_in.
//  2. LSHC, ar=0, arx=36'o777777_777777, sc=-36 (right) -> ar_out=0, arx_out=0. Same operands with sc=+36 -> ar_out=777777777777, arx_out=0.
//  3. ASH, ar=36'o200000_000000, sc=+1 -> ar_out=0 with bit 0 kept (=0), ov=1.
//     ar=36'o400000_000000, sc=-3 -> ar_out=36'o740000_000000, ov=0.
//  4. ROTC, ar=36'o000000_000001, arx=0, sc=-512 -> 64 SHIFT cycles, busy held, then done.
//     512 mod 72 = 8, so the ar bit-35 one lands 8 places right = arx bit 7.
//  5. sc=0 any mode -> done exactly 1 clock after start, outputs = inputs.
//     start pulsed during SHIFT -> ignored; result and latency unchanged.
//  6. abort in the 3rd SHIFT clock of an LSHC sc=+72 -> busy drops next clock, no done.
//     rst_n low mid-op -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the AR/ARX shift engine: default sizes, micro-op
// encodings and the control state encoding.
package shift_pkg;

  localparam int WIDTH  = 36;
  localparam int STEP   = 8;
  localparam int CNTW   = 10;
  localparam int DWIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    SH_LSH  = 2'b00,
    SH_LSHC = 2'b01,
    SH_ASH  = 2'b10,
    SH_ROTC = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift pass of up to STEP positions over the AR/ARX pair.
// Bit 0 of AR (PDP-10 numbering) is val_in[2*WIDTH-1]; ARX bit 35 is val_in[0].
module shift_step #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int STEP  = shift_pkg::STEP,
  localparam int DW   = 2 * WIDTH,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [DW-1:0] val_in,
  input  logic [KW-1:0] k,
  input  logic          dir,
  input  logic [1:0]    mode,
  output logic [DW-1:0] val_out,
  output logic          ov
);
  import shift_pkg::*;

  localparam int FW = WIDTH - 1;

  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] ar_sh;
  logic [FW-1:0]    fld;
  logic             sgn;

  assign ar  = val_in[DW-1:WIDTH];
  assign sgn = ar[WIDTH-1];

  always_comb begin
    val_out = val_in;
    ov      = 1'b0;
    ar_sh   = ar;
    fld     = ar[FW-1:0];
    case (mode)
      SH_LSH: begin
        ar_sh   = dir ? (ar >> k) : (ar << k);
        val_out = {ar_sh, val_in[WIDTH-1:0]};
      end
      SH_LSHC: begin
        val_out = dir ? (val_in >> k) : (val_in << k);
      end
      SH_ASH: begin
        if (dir) begin
          ar_sh   = $unsigned($signed(ar) >>> k);
          val_out = {ar_sh, val_in[WIDTH-1:0]};
        end else begin
          // Walk bit by bit so every bit leaving position 1 is compared to the sign.
          for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
              if (fld[FW-1] != sgn) ov = 1'b1;
              fld = {fld[FW-2:0], 1'b0};
            end
          end
          val_out = {sgn, fld, val_in[WIDTH-1:0]};
        end
      end
      SH_ROTC: begin
        val_out = dir ? ((val_in >> k) | (val_in << (DW - int'(k))))
                      : ((val_in << k) | (val_in >> (DW - int'(k))));
      end
    endcase
  end

endmodule

// File: rtl/shift_loop.sv
// Multi-cycle AR/ARX shift engine: latches operands and a signed count, then
// shifts up to STEP positions per clock until the count is used up.
module shift_loop #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int STEP  = shift_pkg::STEP,
  parameter int CNTW  = shift_pkg::CNTW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNTW-1:0]  sc,
  input  logic [WIDTH-1:0] ar_in,
  input  logic [WIDTH-1:0] arx_in,
  output logic [WIDTH-1:0] ar_out,
  output logic [WIDTH-1:0] arx_out,
  output logic [CNTW-1:0]  sc_rem,
  output logic             busy,
  output logic             done,
  output logic             ov
);
  import shift_pkg::*;

  localparam int DW = 2 * WIDTH;
  localparam int KW = $clog2(STEP + 1);

  shift_state_e    state_q, state_d;
  logic [DW-1:0]   val_q, val_d, step_val;
  logic [CNTW-1:0] mag_q, mag_d, mag_load, mag_next;
  logic [1:0]      mode_q, mode_d;
  logic            dir_q, dir_d;
  logic            ov_q, ov_d;
  logic [KW-1:0]   k;
  logic            step_ov;
  logic            accept;

  assign accept = start & ~abort;

  // Magnitude is unsigned so -512 stays 512; only rotates need counts beyond 2*WIDTH.
  always_comb begin
    mag_load = sc[CNTW-1] ? (~sc + CNTW'(1)) : sc;
    if (mode != SH_ROTC && mag_load > CNTW'(DW)) mag_load = CNTW'(DW);
  end

  always_comb begin
    k = '0;
    if (state_q == ST_SHIFT) k = (mag_q > CNTW'(STEP)) ? KW'(STEP) : mag_q[KW-1:0];
  end

  assign mag_next = mag_q - CNTW'(k);

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .val_in  (val_q),
    .k       (k),
    .dir     (dir_q),
    .mode    (mode_q),
    .val_out (step_val),
    .ov      (step_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (mag_load == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: begin
        if (abort)                 state_d = ST_IDLE;
        else if (mag_next == '0)   state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    val_d  = val_q;
    mag_d  = mag_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    ov_d   = ov_q;
    if (state_q == ST_IDLE && accept) begin
      val_d  = {ar_in, arx_in};
      mag_d  = mag_load;
      mode_d = mode;
      dir_d  = sc[CNTW-1];
      ov_d   = 1'b0;
    end else if (state_q == ST_SHIFT && !abort) begin
      val_d  = step_val;
      mag_d  = mag_next;
      ov_d   = ov_q | step_ov;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      mag_q  <= '0;
      mode_q <= '0;
      dir_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      val_q  <= val_d;
      mag_q  <= mag_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      ov_q   <= ov_d;
    end
  end

  assign ar_out  = val_q[DW-1:WIDTH];
  assign arx_out = val_q[WIDTH-1:0];
  assign sc_rem  = mag_q;
  assign ov      = ov_q;

endmodule
